// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the CPU memory arbiter slice.
package arm_mem_pkg;

  // Owner of the RAM read issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } resp_own_t;

  // Default geometry of the CPU word RAM (4096 x 32).
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // Width of the fetch starvation counter; holds STARVE_MAX up to 15.
  localparam int STARVE_W = 4;

endpackage : arm_mem_pkg

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port CPU word RAM. Load/store has
// fixed priority over instruction fetch, with a starvation guard that hands
// fetch the port after STARVE_MAX consecutive denied cycles. Read data comes
// back one cycle after the grant and is routed to whichever path issued it.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,

  // Instruction-fetch path (read only)
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  // Load/store path
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,

  // RAM port
  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  resp_own_t           resp_own;
  resp_own_t           resp_own_nxt;
  logic                force_if;

  // Grant decision: load/store first unless fetch has waited long enough.
  // NOTE: every grant is qualified with reset_n so nothing reaches the RAM
  // while the block is held in reset, even before the registers have settled.
  always_comb begin
    force_if = (starve_cnt == STARVE_LIM) && if_req;
    ls_gnt   = reset_n && ls_req && !force_if;
    if_gnt   = reset_n && if_req && (!ls_req || force_if);
  end

  // RAM port mux: winner drives the port, idle drives all zeros.
  // NOTE: each output gets a default before the case split so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ls_gnt) begin
      ram_en    = 1'b1;
      ram_we    = ls_we;
      ram_be    = ls_be;
      ram_addr  = ls_addr;
      ram_wdata = ls_wdata;
    end else if (if_gnt) begin
      ram_en    = 1'b1;
      ram_we    = 1'b0;
      ram_be    = '1;
      ram_addr  = if_addr;
      ram_wdata = '0;
    end
  end

  // Owner of the read issued this cycle; stores and idle cycles own nothing.
  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (if_gnt)
      resp_own_nxt = OWN_IF;
    else if (ls_gnt && !ls_we)
      resp_own_nxt = OWN_LS;
  end

  // Starvation counter: counts consecutive cycles fetch asks and is refused.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Response owner register, one cycle behind the grant to match RAM latency.
  always_ff @(posedge clk) begin
    if (!reset_n)
      resp_own <= OWN_NONE;
    else
      resp_own <= resp_own_nxt;
  end

  // Route read data to its owner; a read pending across reset is dropped.
  always_comb begin
    if_rvalid = reset_n && (resp_own == OWN_IF);
    ls_rvalid = reset_n && (resp_own == OWN_LS);
    if_rdata  = if_rvalid ? ram_rdata : '0;
    ls_rdata  = ls_rvalid ? ram_rdata : '0;
  end

  // Only one requester may own the RAM port in any cycle.
  a_one_gnt : assert property (@(posedge clk) !(if_gnt && ls_gnt));

  // The starvation counter never runs past its limit.
  a_starve_bound : assert property (@(posedge clk) disable iff (!reset_n)
                                    starve_cnt <= STARVE_LIM);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural write-first word RAM.
module tb_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_be;
  logic              ls_gnt, ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [0:4095];

  int n_checks = 0;
  int n_fails  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        logic [DATA_W-1:0] merged;
        merged = mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) merged[b*8 +: 8] = ram_wdata[b*8 +: 8];
        mem[ram_addr] <= merged;
        ram_rdata     <= merged;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs away from the active edge, then let logic settle.
  task automatic win(input logic rn, input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic lr, input logic lw, input logic [ADDR_W-1:0] la,
                     input logic [DATA_W-1:0] wd, input logic [3:0] be);
    @(negedge clk);
    reset_n  = rn;
    if_req   = ir;
    if_addr  = ia;
    ls_req   = lr;
    ls_we    = lw;
    ls_addr  = la;
    ls_wdata = wd;
    ls_be    = be;
    #1;
  endtask

  initial begin
    logic exp_if, exp_if_prev, exp_ls_prev;

    for (int a = 0; a < 4096; a++) mem[a] = '0;
    mem[12'h030] = 32'hA5A5_0030;
    mem[12'h040] = 32'h5A5A_0040;
    mem[12'h020] = 32'h1122_3344;
    for (int k = 0; k < 4; k++) mem[16 + k] = 32'hE3A0_0000 | 32'(k);

    // Reset held with both requesters active: nothing may leak out.
    for (int i = 0; i < 3; i++) begin
      win(1'b0, 1'b1, 12'h040, 1'b1, 1'b1, 12'h030, 32'hFFFF_FFFF, 4'hF);
      check("rst_quiet", {26'd0, if_gnt, ls_gnt, ram_en, ram_we, if_rvalid, ls_rvalid}, '0);
    end

    // Contention right after reset: ls x4, then if, repeating.
    exp_if_prev = 1'b0;
    exp_ls_prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      win(1'b1, 1'b1, 12'h040, 1'b1, 1'b0, 12'h030, '0, 4'h0);
      exp_if = ((i % 5) == 4);
      check("cont_if_gnt", 32'(if_gnt), 32'(exp_if));
      check("cont_ls_gnt", 32'(ls_gnt), 32'(!exp_if));
      check("cont_ram_addr", 32'(ram_addr), exp_if ? 32'h040 : 32'h030);
      check("cont_if_rvalid", 32'(if_rvalid), 32'(exp_if_prev));
      check("cont_ls_rvalid", 32'(ls_rvalid), 32'(exp_ls_prev));
      check("cont_if_rdata", if_rdata, exp_if_prev ? 32'h5A5A_0040 : 32'h0);
      check("cont_ls_rdata", ls_rdata, exp_ls_prev ? 32'hA5A5_0030 : 32'h0);
      exp_if_prev = exp_if;
      exp_ls_prev = !exp_if;
    end

    // Idle cycle: port quiet, last fetch of the contention run returns.
    win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("idle_port", {ram_en, ram_we, ram_be, ram_addr, 14'd0}, '0);
    check("idle_wdata", ram_wdata, '0);
    check("idle_gnt", {30'd0, if_gnt, ls_gnt}, '0);
    check("idle_if_rdata", if_rdata, 32'h5A5A_0040);

    // Fetch only, back-to-back over 0x010..0x013.
    for (int i = 0; i < 4; i++) begin
      win(1'b1, 1'b1, 12'(16 + i), 1'b0, 1'b0, '0, '0, 4'h0);
      check("fetch_gnt", {30'd0, if_gnt, ls_gnt}, 32'h2);
      check("fetch_port", {ram_we, ram_be, ram_addr}, {1'b0, 4'hF, 12'(16 + i)});
      check("fetch_rvalid", {30'd0, if_rvalid, ls_rvalid}, (i > 0) ? 32'h2 : 32'h0);
      if (i > 0) check("fetch_rdata", if_rdata, 32'hE3A0_0000 | 32'(i - 1));
    end
    win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("fetch_last_rdata", if_rdata, 32'hE3A0_0003);
    check("fetch_last_ls", {31'd0, ls_rvalid}, '0);
    win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("fetch_drain", {30'd0, if_rvalid, ls_rvalid}, '0);

    // Partial store then immediate load of the same word.
    win(1'b1, 1'b0, '0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'b0011);
    check("st_gnt", {30'd0, if_gnt, ls_gnt}, 32'h1);
    check("st_port", {ram_en, ram_we, ram_be, ram_addr}, {1'b1, 1'b1, 4'b0011, 12'h020});
    check("st_wdata", ram_wdata, 32'hDEAD_BEEF);
    win(1'b1, 1'b0, '0, 1'b1, 1'b0, 12'h020, '0, 4'h0);
    check("ld_gnt", 32'(ls_gnt), 32'h1);
    check("st_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, '0);
    win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("ld_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'h1);
    check("ld_merged", ls_rdata, 32'h1122_BEEF);
    check("ld_if_rdata", if_rdata, '0);

    // Load granted, then reset asserted the next cycle: the read is lost.
    win(1'b1, 1'b0, '0, 1'b1, 1'b0, 12'h030, '0, 4'h0);
    check("mid_ld_gnt", 32'(ls_gnt), 32'h1);
    win(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("mid_rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, '0);
    check("mid_rst_rdata", ls_rdata, '0);
    for (int i = 0; i < 2; i++) begin
      win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
      check("mid_post_rvalid", {30'd0, if_rvalid, ls_rvalid}, '0);
    end

    // Fetch waits two cycles under ls traffic, then gives up.
    for (int i = 0; i < 5; i++) begin
      win(1'b1, (i < 2), 12'h040, 1'b1, 1'b0, 12'h030, '0, 4'h0);
      check("aband_gnt", {30'd0, if_gnt, ls_gnt}, 32'h1);
      check("aband_if_rvalid", 32'(if_rvalid), '0);
    end
    // Counter must be back at zero: fetch waits four full cycles again.
    for (int i = 0; i < 5; i++) begin
      win(1'b1, 1'b1, 12'h040, 1'b1, 1'b0, 12'h030, '0, 4'h0);
      check("restart_gnt", {30'd0, if_gnt, ls_gnt}, (i == 4) ? 32'h2 : 32'h1);
    end
    win(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    check("restart_if_rdata", if_rdata, 32'h5A5A_0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mem_arbiter
